// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets, STATUS bit positions and small constant helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // STATUS reports the FIFO count in a 4-bit field that saturates at 15.
  function automatic logic [3:0] sat_count(input int unsigned c);
    return (c > 15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full and a pop
// while empty are ignored; the read data is the entry at the read pointer.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on the current count, so a push on the same edge as
  // a pop from a full FIFO is still dropped.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write.
  // NOTE: the array has no reset; its contents are never observed before a
  // push writes them, and leaving it out lets the storage map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a FIFO, a bit-timing
// FSM drains it onto tx, and a STATUS register plus an empty interrupt report
// progress.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        tx,
  output logic        irq_empty
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state, state_d;
  logic [BW-1:0]    baud_cnt, baud_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shreg, shreg_d;
  logic             tx_d;
  logic             baud_done;
  logic             overflow;
  logic [31:0]      status;

  logic             wr_tx;
  logic             rd_stat;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] cnt_after;

  // Only the low byte of store data is meaningful.
  wire unused_wdata = ^bus_wdata[31:8];

  assign wr_tx     = bus_we && (bus_addr == TXDATA_OFS);
  assign rd_stat   = bus_re && (bus_addr == STATUS_OFS);
  assign baud_done = (baud_cnt == BW'(DIV - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .wdata (bus_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencing: next state, next line level and FIFO pop decision.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    baud_d   = baud_cnt;
    bit_d    = bit_idx;
    shreg_d  = shreg;
    tx_d     = tx;
    fifo_pop = 1'b0;
    if (state != ST_IDLE) baud_d = baud_done ? '0 : baud_cnt + BW'(1);
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg[0];
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d = {1'b0, shreg[7:1]};
            bit_d   = bit_idx + 3'd1;
            tx_d    = shreg[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            // Back-to-back frame: the next start bit follows with no gap.
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO occupancy after this edge, used so irq_empty tracks the new state.
  assign cnt_after = fifo_count + CNT_W'(wr_tx && !fifo_full) - CNT_W'(fifo_pop);

  // Serializer registers; tx comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_d;
      bit_idx   <= bit_d;
      shreg     <= shreg_d;
      tx        <= tx_d;
      irq_empty <= (state_d == ST_IDLE) && (cnt_after == '0);
    end
  end

  // STATUS word assembled from live state.
  always_comb begin
    status                        = '0;
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_BUSY]             = (state != ST_IDLE);
    status[STAT_OVF]              = overflow;
    status[STAT_CNT_LSB +: 4]     = sat_count(32'(fifo_count));
  end

  // Sticky overflow: set by a store into a full FIFO, cleared by a STATUS
  // load. A simultaneous drop wins so the new event is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_tx && fifo_full) begin
      overflow <= 1'b1;
    end else if (rd_stat) begin
      overflow <= 1'b0;
    end
  end

  // Registered load response; data holds between loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re) bus_rdata <= (bus_addr == STATUS_OFS) ? status : 32'h0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with DIV=16. Expected frames are queued
// as bytes are stored and checked cycle by cycle by a tx monitor.
module tb_mmio_uart_tx;

  localparam int CLK_HZ     = 16;
  localparam int BAUD       = 1;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV        = 16;
  localparam int FRAME      = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        tx;
  logic        irq_empty;

  mmio_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .tx         (tx),
    .irq_empty  (irq_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  int frames_seen = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_status(input bit full, input bit empty,
                                            input bit busy, input bit ovf, input int cnt);
    logic [31:0] s;
    s      = '0;
    s[0]   = full;
    s[1]   = empty;
    s[2]   = busy;
    s[3]   = ovf;
    s[7:4] = (cnt > 15) ? 4'hF : cnt[3:0];
    return s;
  endfunction

  // Checks one frame starting at the current sample; aborts on reset.
  task automatic check_frame();
    frame_t     f;
    logic [9:0] bits;
    frames_seen++;
    check("frame_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    f    = sb.pop_front();
    check("frame_start_cycle", 32'(cyc), 32'(f.start));
    bits = {1'b1, f.data, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (rst !== 1'b1) return;
      check($sformatf("tx_bit%0d_byte%02h", i / DIV, f.data), 32'(tx), 32'(bits[i / DIV]));
    end
  endtask

  // Line monitor: a low level outside a frame marks a start bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) check_frame();
    end
  end

  task automatic store(input logic [2:0] a, input logic [7:0] d, output int edge_n);
    @(negedge clk);
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = {24'hABCDEF, d};
    @(posedge clk);
    #1;
    bus_we = 1'b0;
    edge_n = cyc;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus_re   = 1'b1;
    bus_addr = a;
    @(posedge clk);
    #1;
    bus_re = 1'b0;
    check({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    check({tag, "_rdata"}, bus_rdata, exp);
    @(posedge clk);
    #1;
    check({tag, "_rvalid_drop"}, 32'(bus_rvalid), 32'd0);
    check({tag, "_rdata_hold"}, bus_rdata, exp);
  endtask

  task automatic goto_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || irq_empty !== 1'b1) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_drained_in_time"}, 32'(k < budget), 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int e;
    int fs;
    int lows;

    // Asynchronous reset without any clock edge.
    #1 rst = 1'b0;
    #2;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rvalid", 32'(bus_rvalid), 32'd0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_irq", 32'(irq_empty), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single frame 0x55; the store lands on the first edge after release.
    store(3'h0, 8'h55, n);
    sb.push_back('{8'h55, n + 1});
    check("irq_drops_on_store", 32'(irq_empty), 32'd0);
    goto_edge(n + 160);
    check("stop_bit_high", 32'(tx), 32'd1);
    check("irq_before_frame_end", 32'(irq_empty), 32'd0);
    goto_edge(n + 161);
    check("irq_at_frame_end", 32'(irq_empty), 32'd1);
    check("frames_after_0x55", 32'(frames_seen), 32'd1);

    // Idle STATUS, then loads from TXDATA and an undefined offset.
    load(3'h4, mk_status(0, 1, 0, 0, 0), "status_idle");
    load(3'h0, 32'h0, "load_txdata");
    load(3'h6, 32'h0, "load_undef");

    // Stores to STATUS and undefined offsets have no effect.
    store(3'h4, 8'h77, e);
    store(3'h7, 8'h33, e);
    store(3'h2, 8'h11, e);
    load(3'h4, mk_status(0, 1, 0, 0, 0), "status_after_bad_stores");
    repeat (20) @(posedge clk);
    #1;
    check("no_frame_from_bad_stores", 32'(frames_seen), 32'd1);

    // Back-to-back frames 0x01 and 0x80.
    store(3'h0, 8'h01, n);
    sb.push_back('{8'h01, n + 1});
    store(3'h0, 8'h80, e);
    sb.push_back('{8'h80, n + 1 + FRAME});
    goto_edge(n + 320);
    check("b2b_irq_before_end", 32'(irq_empty), 32'd0);
    goto_edge(n + 321);
    check("b2b_irq_at_end", 32'(irq_empty), 32'd1);
    check("frames_after_b2b", 32'(frames_seen), 32'd3);

    // Nine consecutive stores fit (first pops immediately); tenth overflows.
    fs = frames_seen;
    for (int i = 0; i < 9; i++) begin
      store(3'h0, 8'h10 + 8'(i), e);
      if (i == 0) n = e;
      sb.push_back('{8'h10 + 8'(i), n + 1 + FRAME * i});
    end
    load(3'h4, mk_status(1, 0, 1, 0, 8), "status_nine_stores");
    store(3'h0, 8'hEE, e);
    load(3'h4, mk_status(1, 0, 1, 1, 8), "status_overflow");
    load(3'h4, mk_status(1, 0, 1, 0, 8), "status_overflow_cleared");
    wait_drain(9 * FRAME + 50, "burst");
    check("frames_after_burst", 32'(frames_seen - fs), 32'd9);

    // Reset during DATA bit 3 of 0xA5 aborts the frame and drops the queue.
    store(3'h0, 8'hA5, n);
    sb.push_back('{8'hA5, n + 1});
    store(3'h0, 8'h3C, e);
    sb.push_back('{8'h3C, n + 1 + FRAME});
    goto_edge(n + 70);
    check("mid_frame_bit3", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_tx_high", 32'(tx), 32'd1);
    check("abort_irq", 32'(irq_empty), 32'd1);
    check("abort_rdata", bus_rdata, 32'h0);
    sb.delete();
    fs = frames_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    load(3'h4, mk_status(0, 1, 0, 0, 0), "status_after_reset");
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_frame_after_reset", 32'(lows), 32'd0);
    check("frames_after_reset", 32'(frames_seen - fs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
